uc_arbitro_mem_tiro: RTL

- Control unit that owns the shot memory (N_TIROS slots) and shares it between two requesters.
  - Shot registration: the existing shot-register control unit, using a level req / done handshake.
  - Per-frame movement sweep: this block sequences the sweep itself, reading each slot and writing back the moved position when the slot is active.
- Sits between the game top-level FSM, the shot-register control unit and the shot datapath (memory, address mux, position updater).

---
 rtl/uc_arbitro_mem_tiro_pkg.sv | 26 ++
 rtl/uc_arbitro_mem_tiro_contador.sv | 53 +++++
 rtl/uc_arbitro_mem_tiro.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uc_arbitro_mem_tiro_pkg.sv
// -----------------------------------------------------------------------------
// uc_arbitro_mem_tiro_pkg
// Shared definitions for the shot-memory arbiter control unit.
//   - DB_* : 4-bit codes shown on the hex debug display (db_estado)
//   - estado_t : FSM state encoding, identical to the debug codes so the
//                state register can be exported directly
// -----------------------------------------------------------------------------
package uc_arbitro_mem_tiro_pkg;

    localparam logic [3:0] DB_INICIAL = 4'd0;
    localparam logic [3:0] DB_ESPERA  = 4'd1;
    localparam logic [3:0] DB_CONCEDE = 4'd2;
    localparam logic [3:0] DB_LE_TIRO = 4'd3;
    localparam logic [3:0] DB_ESCREVE = 4'd4;
    localparam logic [3:0] DB_FIM     = 4'd5;

    typedef enum logic [3:0] {
        ST_INICIAL = DB_INICIAL,
        ST_ESPERA  = DB_ESPERA,
        ST_CONCEDE = DB_CONCEDE,
        ST_LE_TIRO = DB_LE_TIRO,
        ST_ESCREVE = DB_ESCREVE,
        ST_FIM     = DB_FIM
    } estado_t;

endpackage

// File: rtl/uc_arbitro_mem_tiro_contador.sv
// -----------------------------------------------------------------------------
// contador_slot_tiro
// Modulo-N_TIROS slot index counter used by the movement sweep.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-low reset (clears the index)
//   limpa  : clear index to 0 (sweep start)
//   conta  : advance index by one; holds at N_TIROS-1
//   valor  : current slot index
//   ultimo : terminal count, high when valor == N_TIROS-1
// -----------------------------------------------------------------------------
module contador_slot_tiro
    import uc_arbitro_mem_tiro_pkg::*;
#(
    parameter int N_TIROS = 4,
    parameter int ADDR_W  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              limpa,
    input  logic              conta,
    output logic [ADDR_W-1:0] valor,
    output logic              ultimo
);

    localparam logic [ADDR_W-1:0] ULTIMO_IDX = ADDR_W'(N_TIROS - 1);

    logic [ADDR_W-1:0] valor_q;
    logic [ADDR_W-1:0] valor_d;

    // Saturating at the last slot keeps the index inside the memory even if
    // conta were asserted on the terminal slot; only limpa/reset return to 0.
    always_comb begin
        valor_d = valor_q;
        if (limpa) begin
            valor_d = '0;
        end else if (conta && (valor_q != ULTIMO_IDX)) begin
            valor_d = valor_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor  = valor_q;
    assign ultimo = (valor_q == ULTIMO_IDX);

endmodule

// File: rtl/uc_arbitro_mem_tiro.sv
// -----------------------------------------------------------------------------
// uc_arbitro_mem_tiro
// Control unit owning the shot memory. It shares the memory between the
// shot-register control unit (req/gnt/done handshake) and a per-frame
// movement sweep that it sequences itself (read slot, write back if active).
// Ports:
//   clock, reset            : clock, synchronous active-low reset
//   inicia_atualizacao      : 1-cycle frame tick requesting a sweep
//   req_registra            : level request from shot-register unit
//   tiro_registrado         : done pulse from shot-register unit
//   tiro_ativo              : active bit of the slot read last cycle
//   gnt_registra            : memory granted to shot-register unit
//   sel_end_varredura       : address mux select (1 = sweep address)
//   endereco_tiro           : sweep slot address
//   le_mem_tiro             : read strobe for the current slot
//   escreve_mem_tiro        : write-enable for the moved shot
//   atualiza_pos            : datapath computes new position
//   atualizando             : high throughout the sweep
//   atualizacao_concluida   : 1-cycle pulse at sweep end
//   overrun                 : sticky, tick arrived during a sweep
//   db_estado               : state code for the debug display
// -----------------------------------------------------------------------------
module uc_arbitro_mem_tiro
    import uc_arbitro_mem_tiro_pkg::*;
#(
    parameter int N_TIROS = 4,
    parameter int ADDR_W  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inicia_atualizacao,
    input  logic              req_registra,
    input  logic              tiro_registrado,
    input  logic              tiro_ativo,
    output logic              gnt_registra,
    output logic              sel_end_varredura,
    output logic [ADDR_W-1:0] endereco_tiro,
    output logic              le_mem_tiro,
    output logic              escreve_mem_tiro,
    output logic              atualiza_pos,
    output logic              atualizando,
    output logic              atualizacao_concluida,
    output logic              overrun,
    output logic [3:0]        db_estado
);

    estado_t state_q, state_d;
    logic    pendente_q, pendente_d;
    logic    overrun_q, overrun_d;
    logic    idx_limpa, idx_conta, idx_ultimo;

    contador_slot_tiro #(
        .N_TIROS (N_TIROS),
        .ADDR_W  (ADDR_W)
    ) u_contador (
        .clock  (clock),
        .reset  (reset),
        .limpa  (idx_limpa),
        .conta  (idx_conta),
        .valor  (endereco_tiro),
        .ultimo (idx_ultimo)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_INICIAL;
            pendente_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pendente_q <= pendente_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        pendente_d            = pendente_q;
        overrun_d             = overrun_q;
        idx_limpa             = 1'b0;
        idx_conta             = 1'b0;
        gnt_registra          = 1'b0;
        sel_end_varredura     = 1'b0;
        le_mem_tiro           = 1'b0;
        escreve_mem_tiro      = 1'b0;
        atualiza_pos          = 1'b0;
        atualizando           = 1'b0;
        atualizacao_concluida = 1'b0;

        case (state_q)
            ST_INICIAL: begin
                state_d = ST_ESPERA;
            end
            ST_ESPERA: begin
                // Sweep has priority over a registration request on the same edge.
                if (inicia_atualizacao || pendente_q) begin
                    state_d   = ST_LE_TIRO;
                    idx_limpa = 1'b1;
                end else if (req_registra) begin
                    state_d = ST_CONCEDE;
                end
            end
            ST_CONCEDE: begin
                gnt_registra = 1'b1;
                // A tick here is remembered rather than pre-empting the grant.
                if (inicia_atualizacao) begin
                    pendente_d = 1'b1;
                end
                if (tiro_registrado || !req_registra) begin
                    state_d = ST_ESPERA;
                end
            end
            ST_LE_TIRO: begin
                sel_end_varredura = 1'b1;
                le_mem_tiro       = 1'b1;
                atualizando       = 1'b1;
                pendente_d        = 1'b0;
                if (inicia_atualizacao) begin
                    overrun_d = 1'b1;
                end
                state_d = ST_ESCREVE;
            end
            ST_ESCREVE: begin
                sel_end_varredura = 1'b1;
                atualizando       = 1'b1;
                escreve_mem_tiro  = tiro_ativo;
                atualiza_pos      = tiro_ativo;
                if (inicia_atualizacao) begin
                    overrun_d = 1'b1;
                end
                if (idx_ultimo) begin
                    state_d = ST_FIM;
                end else begin
                    idx_conta = 1'b1;
                    state_d   = ST_LE_TIRO;
                end
            end
            ST_FIM: begin
                atualizacao_concluida = 1'b1;
                if (inicia_atualizacao) begin
                    overrun_d = 1'b1;
                end
                state_d = ST_ESPERA;
            end
            default: begin
                state_d = ST_INICIAL;
            end
        endcase
    end

    assign overrun   = overrun_q;
    assign db_estado = state_q;

endmodule
